// File: rtl/relu_act_pipe_pkg.sv
// Shared types and saturation helpers for the
// multi-channel activation pipeline.
package relu_pkg;

  typedef enum logic [1:0] {
    ACT_RELU  = 2'b00,
    ACT_LEAKY = 2'b01,
    ACT_CLIP  = 2'b10,
    ACT_IDENT = 2'b11
  } act_mode_e;

  function automatic logic signed [31:0] sat_signed(
    input logic signed [31:0] v,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] r;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    return r;
  endfunction

  function automatic logic signed [31:0] sat_unsigned(
    input logic signed [31:0] v,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] r;
    hi = (32'sd1 <<< w) - 32'sd1;
    if (v > hi)        r = hi;
    else if (v < 0)    r = '0;
    else               r = v;
    return r;
  endfunction

endpackage

// File: rtl/relu_act_pipe_lane.sv
// One channel of activation: takes the pre-scaled
// sum and produces the saturated OUT_W result.
module relu_act_lane
  import relu_pkg::*;
#(
  parameter int IN_W    = 11,
  parameter int OUT_W   = 8,
  parameter int LEAK_SH = 3
) (
  input  logic signed [IN_W-1:0]  x_s,
  input  act_mode_e               mode,
  input  logic        [OUT_W-1:0] clip,
  input  logic                    neg,
  output logic        [OUT_W-1:0] y,
  output logic                    zero
);

  logic signed [31:0] xi;
  logic signed [31:0] ci;

  assign xi = {{(32-IN_W){x_s[IN_W-1]}}, x_s};
  assign ci = {{(32-OUT_W){1'b0}}, clip};

  always_comb begin
    y = '0;
    unique case (mode)
      ACT_RELU:
        y = neg ? '0 : OUT_W'(sat_unsigned(xi, OUT_W));
      ACT_LEAKY:
        y = neg ? OUT_W'(sat_signed(xi >>> LEAK_SH, OUT_W))
                : OUT_W'(sat_signed(xi, OUT_W));
      ACT_CLIP:
        y = neg ? '0 : ((xi > ci) ? clip : OUT_W'(xi));
      ACT_IDENT:
        y = OUT_W'(sat_signed(xi, OUT_W));
      default:
        y = '0;
    endcase
  end

  // Only the clamping modes report a zeroed negative.
  assign zero = neg & ((mode == ACT_RELU) | (mode == ACT_CLIP));

endmodule

// File: rtl/relu_act_pipe.sv
// Two-stage activation pipeline: S1 scales and captures
// controls, S2 is the output register; both skid on ready.
module relu_act_pipe
  import relu_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int IN_W    = 11,
  parameter int OUT_W   = 8,
  parameter int SHIFT   = 2,
  parameter int LEAK_SH = 3,
  parameter int CNT_W   = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_CH*IN_W-1:0]    in_data,
  input  logic [1:0]              mode,
  input  logic [OUT_W-1:0]        clip,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_CH*OUT_W-1:0]   out_data,
  input  logic                    stat_clr,
  output logic [CNT_W-1:0]        zero_cnt
);

  localparam int NZ_W = $clog2(N_CH + 1);

  logic                         s1_valid_q, s1_valid_d;
  logic [N_CH-1:0][IN_W-1:0]    s1_xs_q, s1_xs_d;
  logic [N_CH-1:0]              s1_neg_q, s1_neg_d;
  act_mode_e                    s1_mode_q, s1_mode_d;
  logic [OUT_W-1:0]             s1_clip_q, s1_clip_d;

  logic                         out_valid_q, out_valid_d;
  logic [N_CH*OUT_W-1:0]        out_data_q, out_data_d;
  logic [NZ_W-1:0]              out_nz_q, out_nz_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic                         adv1, adv2, xfer;
  logic [N_CH-1:0][IN_W-1:0]    in_xs;
  logic [N_CH-1:0]              in_neg;
  logic [N_CH*OUT_W-1:0]        lane_y;
  logic [N_CH-1:0]              lane_zero;
  logic [NZ_W-1:0]              nz_sum;
  logic [CNT_W:0]               cnt_sum;

  assign adv2     = !out_valid_q | out_ready;
  assign adv1     = !s1_valid_q | adv2;
  assign xfer     = out_valid_q & out_ready;
  assign in_ready = adv1;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign in_xs[c] =
      $signed(in_data[c*IN_W +: IN_W]) >>> SHIFT;
    assign in_neg[c] = in_data[c*IN_W + IN_W - 1];

    relu_act_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .LEAK_SH (LEAK_SH)
    ) u_lane (
      .x_s  (s1_xs_q[c]),
      .mode (s1_mode_q),
      .clip (s1_clip_q),
      .neg  (s1_neg_q[c]),
      .y    (lane_y[c*OUT_W +: OUT_W]),
      .zero (lane_zero[c])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_xs_d    = s1_xs_q;
    s1_neg_d   = s1_neg_q;
    s1_mode_d  = s1_mode_q;
    s1_clip_d  = s1_clip_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_xs_d   = in_xs;
        s1_neg_d  = in_neg;
        s1_mode_d = act_mode_e'(mode);
        s1_clip_d = clip;
      end
    end
  end

  always_comb begin
    nz_sum = '0;
    for (int c = 0; c < N_CH; c++)
      nz_sum = nz_sum + NZ_W'(lane_zero[c]);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_nz_d    = out_nz_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = lane_y;
        out_nz_d   = nz_sum;
      end
    end
  end

  // Beat's zero count is credited only when it leaves.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(out_nz_q);
    cnt_d   = cnt_q;
    if (stat_clr)
      cnt_d = '0;
    else if (xfer)
      cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      s1_xs_q     <= '0;
      s1_neg_q    <= '0;
      s1_mode_q   <= ACT_RELU;
      s1_clip_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nz_q    <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_xs_q     <= s1_xs_d;
      s1_neg_q    <= s1_neg_d;
      s1_mode_q   <= s1_mode_d;
      s1_clip_q   <= s1_clip_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_nz_q    <= out_nz_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign zero_cnt  = cnt_q;

endmodule

// File: tb/tb_relu_act_pipe.sv
// Scoreboard bench for relu_act_pipe: random and directed
// beats checked against an arithmetic reference model.
module tb_relu_act_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [43:0] in_data = '0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  clip = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        stat_clr = 1'b0;
  logic [15:0] zero_cnt;

  relu_act_pipe dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .clip      (clip),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stat_clr  (stat_clr),
    .zero_cnt  (zero_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    int          nz;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   model_cnt = 0;
  logic ready_cmd = 1'b0;
  bit   rnd_ready = 1'b0;

  always @(posedge CLK) begin
    #2;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic exp_t model(input logic [43:0] d,
                                 input logic [1:0] m,
                                 input logic [7:0] cl);
    exp_t        e;
    logic [10:0] raw;
    int          x, xs, r;
    e.data = '0;
    e.nz   = 0;
    for (int c = 0; c < 4; c++) begin
      raw = d[c*11 +: 11];
      x   = int'($signed(raw));
      xs  = fdiv(x, 4);
      case (m)
        2'b00: r = (x < 0) ? 0 : clampi(xs, 0, 255);
        2'b01: r = (x < 0) ? clampi(fdiv(xs, 8), -128, 127)
                           : clampi(xs, -128, 127);
        2'b10: r = (x < 0) ? 0 : ((xs > int'(cl)) ? int'(cl) : xs);
        default: r = clampi(xs, -128, 127);
      endcase
      if (x < 0 && (m == 2'b00 || m == 2'b10)) e.nz++;
      e.data[c*8 +: 8] = r[7:0];
    end
    return e;
  endfunction

  function automatic logic [43:0] pk(input int a, input int b,
                                     input int c, input int d);
    return {d[10:0], c[10:0], b[10:0], a[10:0]};
  endfunction

  task automatic send(input logic [43:0] d, input logic [1:0] m,
                      input logic [7:0] cl);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    clip     = cl;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        if (!RST) q.push_back(model(d, m, cl));
        acc = 1;
        break;
      end
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && q.size() != 0; i++) begin
      @(posedge CLK); #1;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    repeat (2) begin @(posedge CLK); #1; end
  endtask

  task automatic directed(input logic [43:0] d, input logic [1:0] m,
                          input logic [7:0] cl, input logic [31:0] xd,
                          input logic [15:0] xzc);
    send(d, m, cl);
    @(negedge CLK);
    chk("lat_s1_idle", 64'(out_valid), 64'd0);
    @(negedge CLK);
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("dir_data", 64'(out_data), 64'(xd));
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("dir_zero_cnt", 64'(zero_cnt), 64'(xzc));
    @(posedge CLK); #1;
  endtask

  // Monitor: pops and compares every output transfer.
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;
  always @(negedge CLK) begin : mon
    exp_t e;
    if (RST) begin
      q.delete();
      model_cnt  = 0;
      prev_stall = 0;
    end else begin
      chk("zero_cnt", 64'(zero_cnt), 64'(model_cnt));
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_out: got %0h expected none", out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.data));
          if (!stat_clr) begin
            model_cnt = model_cnt + e.nz;
            if (model_cnt > 65535) model_cnt = 65535;
          end
        end
      end
      if (stat_clr) model_cnt = 0;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  logic [43:0] bv [5];
  logic [43:0] rd;
  int          seen;

  initial begin
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_zero_cnt", 64'(zero_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    ready_cmd = 1'b1;
    @(posedge CLK); #1;

    directed(pk(400, -5, 1023, 0), 2'b00, 8'd0, 32'h00FF0064, 16'd1);
    directed(pk(-400, 600, -1024, 3), 2'b01, 8'd0, 32'h00E07FF3, 16'd1);
    directed(pk(400, 200, -1, 252), 2'b10, 8'd64, 32'h3F003240, 16'd2);

    for (int i = 0; i < 5; i++) begin
      bv[i][31:0]  = $urandom();
      bv[i][43:32] = 12'($urandom());
    end
    ready_cmd = 1'b0;
    send(bv[0], 2'b11, 8'd0);
    send(bv[1], 2'b11, 8'd0);
    in_valid = 1'b1;
    in_data  = bv[2];
    mode     = 2'b11;
    repeat (4) begin
      @(negedge CLK);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge CLK); #1;
    end
    ready_cmd = 1'b1;
    for (int i = 2; i < 5; i++) send(bv[i], 2'b11, 8'd0);
    drain();

    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rd[31:0]  = $urandom();
      rd[43:32] = 12'($urandom());
      send(rd, 2'($urandom()), 8'($urandom()));
      if ($urandom_range(0, 4) == 0) begin @(posedge CLK); #1; end
    end
    rnd_ready = 1'b0;
    ready_cmd = 1'b1;
    drain();

    for (int i = 0; i < 16400; i++)
      send(pk(-1024, -3, -1024, -700), 2'b00, 8'd0);
    drain();
    @(negedge CLK);
    chk("zc_saturated", 64'(zero_cnt), 64'hFFFF);
    @(posedge CLK); #1;

    send(pk(-8, -8, 5, -9), 2'b10, 8'd20);
    @(posedge CLK); #1;
    stat_clr = 1'b1;
    @(negedge CLK);
    chk("clr_same_xfer", 64'(out_valid & out_ready), 64'd1);
    @(posedge CLK); #1;
    stat_clr = 1'b0;
    @(negedge CLK);
    chk("zc_cleared", 64'(zero_cnt), 64'd0);
    @(posedge CLK); #1;

    send(pk(-50, -60, -70, 80), 2'b00, 8'd0);
    drain();
    ready_cmd = 1'b0;
    send(pk(300, -300, 40, 1000), 2'b00, 8'd0);
    send(pk(-9, 9, -90, 90), 2'b11, 8'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_out_data", 64'(out_data), 64'd0);
    chk("rst2_zero_cnt", 64'(zero_cnt), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    ready_cmd = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    chk("rst2_no_emit", 64'(seen), 64'd0);
    @(posedge CLK); #1;

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_act_pipe.md
Name: relu_act_pipe

Overview:
- Parametrised, pipelined, multi-channel activation unit; successor to the single-channel combinational 11b->8b ReLU mux bank.
- Takes N_CH signed accumulator sums per beat and applies a run-time-selected activation: ReLU, leaky ReLU, clipped ReLU or identity.
- Applies a fixed output scaling shift and saturates; moves data over valid/ready handshakes on both sides.
- Sits between the MAC accumulator array and the next-layer input buffer; keeps a saturating count of negative-clamped outputs for debug.

Parameters:
- N_CH, 4, channels per beat
- IN_W, 11, signed input width per channel
- OUT_W, 8, output width per channel
- SHIFT, 2, arithmetic right shift applied before activation (scaling)
- LEAK_SH, 3, extra arithmetic right shift applied to negatives in leaky mode
- CNT_W, 16, width of the statistics counter

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  N_CH*IN_W  packed signed sums; channel c at [c*IN_W +: IN_W]
- mode  in  2  00 ReLU, 01 leaky, 10 clipped ReLU, 11 identity; sampled on input acceptance
- clip  in  OUT_W  unsigned clip ceiling for mode 10; sampled on input acceptance
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_data  out  N_CH*OUT_W  packed results, same channel layout
- stat_clr  in  1  synchronous clear of zero_cnt
- zero_cnt  out  CNT_W  saturating count of channels clamped to 0 (negative input, mode 00/10)

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset: s1_valid=0, out_valid=0, out_data=0, zero_cnt=0. in_ready=1 in the first cycle after reset. RST asserted mid-operation discards all in-flight beats next edge; nothing is emitted afterwards.
- Stage 1 (S1): on acceptance, registers per channel x_s = x >>> SHIFT (sign-extended, floor rounding), plus mode, clip and the sign bit.
- Stage 2 (S2, output register): computes the activation from S1 and loads out_data/out_valid.
- Pipeline advance: adv2 = !out_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 (combinational, no input-to-output comb path except the ready chain).
- Latency: 2 cycles from acceptance to out_valid with out_ready held high. Sustains 1 beat/cycle.
- Backpressure: output holds stable while out_valid & !out_ready. No loss, duplication or reordering; at most 2 beats are buffered.
- Mode 00 (ReLU): negative -> 0; else min(x_s, 2^OUT_W-1), unsigned.
- Mode 01 (leaky): non-negative -> min(x_s, 2^(OUT_W-1)-1); negative -> max(x_s >>> LEAK_SH, -2^(OUT_W-1)). Output is two's complement.
- Mode 10 (clipped): negative -> 0; else min(x_s, clip), unsigned.
- Mode 11 (identity): x_s saturated to the signed OUT_W range.
- Zero input is not negative and is not counted.
- zero_cnt: on each output transfer (out_valid & out_ready), add the number of channels with a negative input in mode 00/10.
  - Saturates at 2^CNT_W-1.
  - stat_clr has priority over a same-cycle increment: the counter result is 0.
- mode and clip changes between beats take effect per beat, with no flush.

Decomposition:
- Shared package relu_pkg:
  - act_mode_e enum (ACT_RELU=2'b00, ACT_LEAKY=2'b01, ACT_CLIP=2'b10, ACT_IDENT=2'b11).
  - sat_signed / sat_unsigned width-generic functions.
- Sub-module relu_act_lane: combinational per-channel activation plus saturation, instantiated N_CH times in a generate loop.
- Pipeline registers, handshake and counter stay in the top module.

Test Plan (defaults):
- Mode 00, channels {400, -5, 1023, 0}, out_ready=1 -> two cycles later out_data {100, 0, 255, 0}; zero_cnt=1.
- Mode 01, channels {-400, 600, -1024, 3} -> {8'hF3 (-13), 127, 8'hE0 (-32), 0}; zero_cnt unchanged.
- Mode 10, clip=64, channels {400, 200, -1, 252} -> {64, 50, 0, 63}; zero_cnt +1.
- Back-to-back 5 beats, out_ready low for cycles 2-6:
  - in_ready drops after 2 beats are buffered.
  - All 5 beats emerge in order, unchanged, held stable while stalled.
- zero_cnt preloaded near 2^16-1 via repeated all-negative ReLU beats -> saturates at 16'hFFFF. stat_clr asserted on the same cycle as a negative-beat transfer -> 0.
- RST pulsed while 2 beats are in flight -> next cycle out_valid=0, out_data=0, zero_cnt=0, in_ready=1; neither beat is ever emitted.
